foc_sample_frontend: RTL and testbench
======================================

Name: foc_sample_frontend

Overview:
Initiator side of the FOC control-loop valid/ready handshake. It generates the periodic loop trigger and runs the ADC conversion handshake. It converts raw unsigned phase-current samples into signed Q-format currents, latches resolver angle, target current and PWM period, then presents one transaction to the FOC top with a single-cycle valid once ready is high. It also counts overruns (trigger while busy) and flags ADC timeouts.

Parameters:
D_WIDTH, 16, width of all FOC-side data words
ADC_BITS, 12, raw ADC sample width (unsigned, offset-binary)
ADC_OFFSET, 2048, zero-current ADC code subtracted from each raw sample
Q_SHIFT, 3, left shift applied after offset removal to reach the FOC Q format
TIMEOUT, 255, max cycles waiting for adc_done before abort
CNT_W, 8, overrun counter width

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
enable  in  1  loop trigger enable
loop_div  in  D_WIDTH  trigger period in cycles minus one; 0 = no triggers
clr  in  1  clears overrun_cnt and adc_err
adc_start  out  1  one-cycle conversion request
adc_done  in  1  conversion complete; raw samples valid this cycle
adc_a, adc_b, adc_c  in  ADC_BITS  raw phase samples
angle_raw  in  D_WIDTH  resolver angle
target_in  in  D_WIDTH  target current from ECU
period_in  in  D_WIDTH  PWM period top
angle_out  out  D_WIDTH  latched angle
currA_out, currB_out, currC_out  out  D_WIDTH  signed scaled currents
currT_out  out  D_WIDTH  latched target
periodTop_out  out  D_WIDTH  latched period
foc_valid  out  1  transaction valid (one-cycle pulse)
foc_ready  in  1  FOC top ready to accept
busy  out  1  high in any state other than IDLE
overrun_cnt  out  CNT_W  saturating count of dropped triggers
adc_err  out  1  sticky ADC timeout flag

Behaviour:
- Reset (rstb low, async): all outputs 0, state IDLE, trigger counter 0.
- Trigger counter: when enable=1 and loop_div!=0, counts 0..loop_div. It raises tick on the cycle it equals loop_div, then wraps to 0. A loop_div change takes effect at the next wrap. With enable=0 the counter is held at 0 and no ticks occur; an in-flight transaction still completes.
- FSM states: IDLE, CONVERT, SCALE, WAIT_RDY.
- IDLE: on tick, register adc_start=1 for exactly one cycle, latch angle_raw, target_in and period_in, and go to CONVERT.
- CONVERT: the timeout counter is cleared on entry.
  - adc_done=1: capture adc_a/b/c and go to SCALE.
  - Counter reaches TIMEOUT without adc_done: set adc_err, go to IDLE, no foc_valid, output registers unchanged.
  - An adc_done arriving outside CONVERT is ignored.
- SCALE: currX_out = sat(((signed)adcX - ADC_OFFSET) << Q_SHIFT). The subtraction is done at ADC_BITS+1 signed width. Saturate to the D_WIDTH signed range. Load angle_out, currT_out and periodTop_out from the latches, then go to WAIT_RDY.
- WAIT_RDY: when foc_ready=1, assert foc_valid for exactly the next cycle and go to IDLE. Otherwise hold indefinitely.
- Latency: tick at T → adc_start high at T+1. adc_done at D → foc_valid high at D+3 if foc_ready is held high.
- Data outputs stay stable from the foc_valid cycle until the next SCALE. The FOC top may sample them any time after valid.
- Overrun: a tick while state!=IDLE increments overrun_cnt, saturating at all-ones, and the tick is dropped. The in-flight transaction is unaffected.
- clr=1 clears overrun_cnt and adc_err. If clr and an overrun/timeout event occur in the same cycle, clr wins.
- busy is combinational: (state != IDLE).
- Reset mid-operation returns to IDLE immediately. Any pending valid is lost and no adc_start is reissued.

Test Plan:
- loop_div=9, enable=1, adc_done 2 cycles after adc_start, foc_ready=1 → adc_start every 10 cycles; foc_valid 3 cycles after adc_done; overrun_cnt=0.
- adc_a=2048, adc_b=3048, adc_c=0 → currA_out=0, currB_out=8000, currC_out=-16384 (0xC000); adc_a=4095 → 16376.
- foc_ready held low 20 cycles with loop_div=4 → foc_valid only after ready rises; overrun_cnt increments once per dropped tick; an 8-bit count stops at 255.
- adc_done never asserted → after 255 CONVERT cycles adc_err=1, state IDLE, no foc_valid; clr pulse → adc_err=0, overrun_cnt=0.
- rstb asserted during CONVERT → all outputs 0 asynchronously; after release, normal operation resumes at the next tick.
- enable dropped during WAIT_RDY → the pending transaction completes with a single foc_valid, then no further adc_start.

Source files
------------

// File: rtl/foc_sample_frontend.sv
// Sample front end for the FOC control loop.
// Generates the periodic loop trigger and runs the ADC conversion handshake.
// Converts the raw offset-binary phase samples to signed Q-format currents and
// latches angle, target and PWM period. It then offers one transaction to the
// FOC top with a single-cycle foc_valid once foc_ready is high.
//
// Ports:
//   clk, rstb                     clock, async active-low reset
//   enable, loop_div              trigger enable and period (cycles - 1, 0 = off)
//   clr                           clears overrun_cnt and adc_err
//   adc_start / adc_done          conversion request pulse / completion strobe
//   adc_a, adc_b, adc_c           raw phase samples, valid with adc_done
//   angle_raw, target_in,         live inputs, latched at each trigger
//   period_in
//   angle_out, curr*_out,         transaction data, stable from foc_valid
//   periodTop_out                 until the next SCALE
//   foc_valid / foc_ready         transaction handshake
//   busy                          state != IDLE
//   overrun_cnt, adc_err          saturating dropped-trigger count, sticky timeout
module foc_sample_frontend #(
  parameter int unsigned D_WIDTH    = 16,
  parameter int unsigned ADC_BITS   = 12,
  parameter int unsigned ADC_OFFSET = 2048,
  parameter int unsigned Q_SHIFT    = 3,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                enable,
  input  logic [D_WIDTH-1:0]  loop_div,
  input  logic                clr,
  output logic                adc_start,
  input  logic                adc_done,
  input  logic [ADC_BITS-1:0] adc_a,
  input  logic [ADC_BITS-1:0] adc_b,
  input  logic [ADC_BITS-1:0] adc_c,
  input  logic [D_WIDTH-1:0]  angle_raw,
  input  logic [D_WIDTH-1:0]  target_in,
  input  logic [D_WIDTH-1:0]  period_in,
  output logic [D_WIDTH-1:0]  angle_out,
  output logic [D_WIDTH-1:0]  currA_out,
  output logic [D_WIDTH-1:0]  currB_out,
  output logic [D_WIDTH-1:0]  currC_out,
  output logic [D_WIDTH-1:0]  currT_out,
  output logic [D_WIDTH-1:0]  periodTop_out,
  output logic                foc_valid,
  input  logic                foc_ready,
  output logic                busy,
  output logic [CNT_W-1:0]    overrun_cnt,
  output logic                adc_err
);

  localparam int unsigned ToW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam longint      DMax = (longint'(1) <<< (D_WIDTH - 1)) - 1;
  localparam longint      DMin = -(longint'(1) <<< (D_WIDTH - 1));

  typedef enum logic [1:0] {StIdle, StConvert, StScale, StWaitRdy} state_e;

  // Offset removal at ADC_BITS+1 signed width, shift to Q format, then
  // saturate to the signed D_WIDTH range.
  function automatic logic [D_WIDTH-1:0] scale_sample(input logic [ADC_BITS-1:0] raw);
    logic signed [ADC_BITS:0] diff;
    logic signed [63:0]       wide;
    diff = $signed({1'b0, raw}) - $signed((ADC_BITS + 1)'(ADC_OFFSET));
    wide = 64'(diff) <<< Q_SHIFT;
    if (wide > DMax) begin
      return D_WIDTH'(DMax);
    end else if (wide < DMin) begin
      return D_WIDTH'(DMin);
    end
    return D_WIDTH'(wide);
  endfunction

  state_e               state_q, state_d;
  logic [D_WIDTH-1:0]   trig_q, trig_d;
  logic [D_WIDTH-1:0]   div_q;
  logic [D_WIDTH-1:0]   cur_div;
  logic                 tick;
  logic [ToW-1:0]       to_q, to_d;
  logic                 adc_start_q, adc_start_d;
  logic                 valid_q, valid_d;
  logic [CNT_W-1:0]     ovr_q, ovr_d;
  logic                 err_q, err_d;
  logic                 latch_en, cap_en, load_en, timeout;

  logic [D_WIDTH-1:0]   ang_l_q, tgt_l_q, per_l_q;
  logic [ADC_BITS-1:0]  raw_a_q, raw_b_q, raw_c_q;
  logic [D_WIDTH-1:0]   ang_o_q, cur_a_q, cur_b_q, cur_c_q, tgt_o_q, per_o_q;

  // A new loop_div is only picked up while the counter sits at 0, so a
  // mid-period change waits for the wrap.
  always_comb begin
    cur_div = (trig_q == '0) ? loop_div : div_q;
    tick    = enable && (cur_div != '0) && (trig_q == cur_div);
    if (!enable || (cur_div == '0) || tick) begin
      trig_d = '0;
    end else begin
      trig_d = trig_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    to_d        = to_q;
    adc_start_d = 1'b0;
    valid_d     = 1'b0;
    latch_en    = 1'b0;
    cap_en      = 1'b0;
    load_en     = 1'b0;
    timeout     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          adc_start_d = 1'b1;
          latch_en    = 1'b1;
          to_d        = '0;
          state_d     = StConvert;
        end
      end
      StConvert: begin
        if (adc_done) begin
          cap_en  = 1'b1;
          state_d = StScale;
        end else if (to_q == ToW'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StScale: begin
        load_en = 1'b1;
        state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (foc_ready) begin
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // clr takes priority over a same-cycle overrun or timeout.
  always_comb begin
    ovr_d = ovr_q;
    err_d = err_q;
    if (clr) begin
      ovr_d = '0;
      err_d = 1'b0;
    end else begin
      if (tick && (state_q != StIdle) && (ovr_q != '1)) begin
        ovr_d = ovr_q + 1'b1;
      end
      if (timeout) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= StIdle;
      trig_q      <= '0;
      div_q       <= '0;
      to_q        <= '0;
      adc_start_q <= 1'b0;
      valid_q     <= 1'b0;
      ovr_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_d;
      div_q       <= cur_div;
      to_q        <= to_d;
      adc_start_q <= adc_start_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ang_l_q <= '0;
      tgt_l_q <= '0;
      per_l_q <= '0;
      raw_a_q <= '0;
      raw_b_q <= '0;
      raw_c_q <= '0;
      ang_o_q <= '0;
      cur_a_q <= '0;
      cur_b_q <= '0;
      cur_c_q <= '0;
      tgt_o_q <= '0;
      per_o_q <= '0;
    end else begin
      if (latch_en) begin
        ang_l_q <= angle_raw;
        tgt_l_q <= target_in;
        per_l_q <= period_in;
      end
      if (cap_en) begin
        raw_a_q <= adc_a;
        raw_b_q <= adc_b;
        raw_c_q <= adc_c;
      end
      if (load_en) begin
        ang_o_q <= ang_l_q;
        cur_a_q <= scale_sample(raw_a_q);
        cur_b_q <= scale_sample(raw_b_q);
        cur_c_q <= scale_sample(raw_c_q);
        tgt_o_q <= tgt_l_q;
        per_o_q <= per_l_q;
      end
    end
  end

  assign adc_start     = adc_start_q;
  assign foc_valid     = valid_q;
  assign busy          = (state_q != StIdle);
  assign overrun_cnt   = ovr_q;
  assign adc_err       = err_q;
  assign angle_out     = ang_o_q;
  assign currA_out     = cur_a_q;
  assign currB_out     = cur_b_q;
  assign currC_out     = cur_c_q;
  assign currT_out     = tgt_o_q;
  assign periodTop_out = per_o_q;

endmodule

// File: tb/tb_foc_sample_frontend.sv
// Self-checking bench for foc_sample_frontend: directed phases with random
// data, currents and overrun counts predicted by a plain arithmetic model.
module tb_foc_sample_frontend;

  localparam int AdcOffset = 2048;
  localparam int QShift    = 3;

  logic        clk = 1'b0;
  logic        rstb;
  logic        enable;
  logic [15:0] loop_div;
  logic        clr;
  logic        adc_start;
  logic        adc_done;
  logic [11:0] adc_a, adc_b, adc_c;
  logic [15:0] angle_raw, target_in, period_in;
  logic [15:0] angle_out, currA_out, currB_out, currC_out, currT_out, periodTop_out;
  logic        foc_valid;
  logic        foc_ready;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        adc_err;

  foc_sample_frontend dut (
    .clk           (clk),
    .rstb          (rstb),
    .enable        (enable),
    .loop_div      (loop_div),
    .clr           (clr),
    .adc_start     (adc_start),
    .adc_done      (adc_done),
    .adc_a         (adc_a),
    .adc_b         (adc_b),
    .adc_c         (adc_c),
    .angle_raw     (angle_raw),
    .target_in     (target_in),
    .period_in     (period_in),
    .angle_out     (angle_out),
    .currA_out     (currA_out),
    .currB_out     (currB_out),
    .currC_out     (currC_out),
    .currT_out     (currT_out),
    .periodTop_out (periodTop_out),
    .foc_valid     (foc_valid),
    .foc_ready     (foc_ready),
    .busy          (busy),
    .overrun_cnt   (overrun_cnt),
    .adc_err       (adc_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_ovr  = 0;
  int per_m    = 0;  // trigger period the overrun model uses, 0 = off
  int per_next = 0;
  int phase0   = 0;  // cycle of the most recent trigger
  logic [15:0] e_a, e_b, e_c, e_ang, e_tgt, e_per;

  function automatic logic [15:0] exp_curr(input int raw);
    int v;
    v = (raw - AdcOffset) * (1 << QShift);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; a trigger that lands while busy is a dropped tick.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (per_m > 0 && busy && ((cyc - phase0) % per_m) == 0 && exp_ovr < 255) exp_ovr++;
  endtask

  task automatic wait_start(input int limit, output bit got, output int s_cyc);
    got   = 1'b0;
    s_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (adc_start === 1'b1) begin
        got    = 1'b1;
        s_cyc  = cyc;
        phase0 = cyc - 1;
        per_m  = per_next;
        break;
      end
    end
    if (!got) chk("adc_start_timeout", 32'(got), 32'd1);
  endtask

  task automatic quiesce();
    per_m     = 0;
    per_next  = 0;
    enable    = 1'b0;
    foc_ready = 1'b1;
    adc_done  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!busy) break;
    end
    adc_done = 1'b0;
    step();
    chk("quiesce_idle", 32'(busy), 32'd0);
  endtask

  task automatic txn(input int dly, input int hold, input logic [11:0] a, input logic [11:0] b,
                     input logic [11:0] c, input bit drop_en, output int s_cyc);
    bit got;
    bit seen;
    e_ang     = 16'($urandom);
    e_tgt     = 16'($urandom);
    e_per     = 16'($urandom);
    angle_raw = e_ang;
    target_in = e_tgt;
    period_in = e_per;
    foc_ready = (hold == 0);
    wait_start(1000, got, s_cyc);
    if (got) begin
      angle_raw = 16'($urandom);
      target_in = 16'($urandom);
      period_in = 16'($urandom);
      step();
      chk("adc_start_pulse", 32'(adc_start), 32'd0);
      repeat (dly - 1) step();
      adc_a    = a;
      adc_b    = b;
      adc_c    = c;
      adc_done = 1'b1;
      step();
      adc_done = 1'b0;
      adc_a    = 12'($urandom);
      adc_b    = 12'($urandom);
      adc_c    = 12'($urandom);
      chk("valid_early1", 32'(foc_valid), 32'd0);
      step();
      chk("valid_early2", 32'(foc_valid), 32'd0);
      chk("busy_in_flight", 32'(busy), 32'd1);
      if (hold > 0) begin
        seen = 1'b0;
        for (int i = 0; i < hold; i++) begin
          step();
          if (foc_valid) seen = 1'b1;
          if (drop_en && i == hold / 2) begin
            enable = 1'b0;
            per_m  = 0;
          end
        end
        chk("valid_without_ready", 32'(seen), 32'd0);
        foc_ready = 1'b1;
      end
      step();
      e_a = exp_curr(int'(a));
      e_b = exp_curr(int'(b));
      e_c = exp_curr(int'(c));
      chk("foc_valid", 32'(foc_valid), 32'd1);
      chk("currA", 32'(currA_out), 32'(e_a));
      chk("currB", 32'(currB_out), 32'(e_b));
      chk("currC", 32'(currC_out), 32'(e_c));
      chk("angle", 32'(angle_out), 32'(e_ang));
      chk("target", 32'(currT_out), 32'(e_tgt));
      chk("period", 32'(periodTop_out), 32'(e_per));
      chk("busy_after_valid", 32'(busy), 32'd0);
      step();
      chk("valid_single", 32'(foc_valid), 32'd0);
      chk("currA_stable", 32'(currA_out), 32'(e_a));
      chk("overrun", 32'(overrun_cnt), 32'(exp_ovr));
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s1, s2, s3, dur, n_st, n_v;
    bit got, seen;

    rstb      = 1'b0;
    enable    = 1'b0;
    loop_div  = '0;
    clr       = 1'b0;
    adc_done  = 1'b0;
    adc_a     = '0;
    adc_b     = '0;
    adc_c     = '0;
    angle_raw = '0;
    target_in = '0;
    period_in = '0;
    foc_ready = 1'b0;
    step();
    step();
    chk("rst_adc_start", 32'(adc_start), 32'd0);
    chk("rst_valid", 32'(foc_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr_err", {23'd0, adc_err, overrun_cnt}, 32'd0);
    chk("rst_curr_ab", {currA_out, currB_out}, 32'd0);
    chk("rst_curr_ct", {currC_out, currT_out}, 32'd0);
    chk("rst_ang_per", {angle_out, periodTop_out}, 32'd0);
    rstb = 1'b1;
    step();

    // Periodic loop with the fixed scaling vectors.
    loop_div = 16'd9;
    per_next = 10;
    enable   = 1'b1;
    txn(2, 0, 12'd2048, 12'd3048, 12'd0, 1'b0, s1);
    txn(2, 0, 12'd4095, 12'($urandom), 12'($urandom), 1'b0, s2);
    txn(2, 0, 12'($urandom), 12'($urandom), 12'($urandom), 1'b0, s3);
    chk("start_period1", 32'(s2 - s1), 32'd10);
    chk("start_period2", 32'(s3 - s2), 32'd10);

    // ADC never answers: timeout after 255 CONVERT cycles.
    enable = 1'b0;
    step();
    loop_div  = 16'd300;
    per_next  = 301;
    foc_ready = 1'b1;
    enable    = 1'b1;
    wait_start(1000, got, s1);
    dur  = 0;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      dur++;
      step();
      if (foc_valid) seen = 1'b1;
    end
    enable = 1'b0;
    chk("timeout_cycles", 32'(dur), 32'd255);
    chk("timeout_no_valid", 32'(seen), 32'd0);
    chk("timeout_err", 32'(adc_err), 32'd1);
    chk("timeout_hold_a", 32'(currA_out), 32'(e_a));
    chk("timeout_hold_ang", 32'(angle_out), 32'(e_ang));

    // Ready held low: dropped ticks counted.
    step();
    loop_div = 16'd4;
    per_next = 5;
    enable   = 1'b1;
    txn($urandom_range(1, 3), 20, 12'($urandom), 12'($urandom), 12'($urandom), 1'b0, s1);
    quiesce();

    // Fast triggers, long stall: counter saturates.
    loop_div = 16'd1;
    per_next = 2;
    enable   = 1'b1;
    txn(1, 600, 12'($urandom), 12'($urandom), 12'($urandom), 1'b0, s1);
    chk("overrun_sat", 32'(overrun_cnt), 32'd255);
    quiesce();

    clr = 1'b1;
    step();
    clr     = 1'b0;
    exp_ovr = 0;
    chk("clr_overrun", 32'(overrun_cnt), 32'd0);
    chk("clr_err", 32'(adc_err), 32'd0);

    // Asynchronous reset during CONVERT.
    loop_div = 16'd6;
    per_next = 7;
    enable   = 1'b1;
    wait_start(1000, got, s1);
    step();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #3;
    rstb = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_start_valid", {30'd0, adc_start, foc_valid}, 32'd0);
    chk("arst_curr_ab", {currA_out, currB_out}, 32'd0);
    chk("arst_ang_t", {angle_out, currT_out}, 32'd0);
    step();
    rstb    = 1'b1;
    exp_ovr = 0;
    per_m   = 0;
    step();
    chk("post_rst_no_start", 32'(adc_start), 32'd0);
    chk("post_rst_idle", 32'(busy), 32'd0);
    txn($urandom_range(1, 3), 0, 12'($urandom), 12'($urandom), 12'($urandom), 1'b0, s1);
    quiesce();

    // enable dropped while waiting for ready.
    loop_div = 16'd100;
    per_next = 101;
    enable   = 1'b1;
    txn(2, 20, 12'($urandom), 12'($urandom), 12'($urandom), 1'b1, s1);
    n_st = 0;
    n_v  = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (adc_start) n_st++;
      if (foc_valid) n_v++;
    end
    chk("no_start_after_disable", 32'(n_st), 32'd0);
    chk("no_valid_after_disable", 32'(n_v), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
